oam_dma_controller: RTL and testbench
=====================================

OAM_DMA_CONTROLLER -- requirements
Module: oam_dma_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, CPU cycle clock, all state on rising edge) and reset_N (input, 1, active-low async reset).
REQ-002 SHALL have the following ports:
- cpuAddress_IN  input  16  CPU bus address for the current cycle.
- cpuData_IN  input  8  CPU write data.
- cpuWrite_EN  input  1  CPU write strobe for the current cycle.
- busData_IN  input  8  memory read data returned to DMA.
- rdy_OUT  output  1  CPU ready; low halts CPU.
- dmaBusOwn_OUT  output  1  DMA drives the address/data bus.
- dmaAddress_OUT  output  16  DMA bus address.
- dmaData_OUT  output  8  DMA write data.
- dmaRead_EN  output  1  DMA read strobe.
- dmaWrite_EN  output  1  DMA write strobe.
- busy_OUT  output  1  transfer in progress.

Function
REQ-003 SHALL trigger on a clk edge where cpuWrite_EN=1 and cpuAddress_IN=16'h4014 while in IDLE, capturing cpuData_IN as the source page.
REQ-004 SHALL use states IDLE, HALT, ALIGN, READ and WRITE.
REQ-005 SHALL make these transitions:
- IDLE->HALT on trigger.
- HALT->ALIGN or READ (see REQ-013).
- ALIGN->READ.
- READ->WRITE.
- WRITE->READ while index<255; WRITE->IDLE at index=255.
REQ-006 SHALL hold rdy_OUT=0 and busy_OUT=1 in every state except IDLE; rdy_OUT=1 and busy_OUT=0 in IDLE.
REQ-007 SHALL assert dmaBusOwn_OUT only in READ and WRITE; in HALT and ALIGN the bus is idle (no strobes, dmaBusOwn_OUT=0).
REQ-008 SHALL, in READ: drive dmaAddress_OUT={page,index} and dmaRead_EN=1, and capture busData_IN into the byte register at the cycle-end edge.
REQ-009 SHALL, in WRITE: drive dmaAddress_OUT=16'h2004, dmaData_OUT=byte register and dmaWrite_EN=1, then increment the 8-bit index at the cycle-end edge.
REQ-010 SHALL never let the index wrap into a 257th transfer; the byte at {page,8'hFF} is the last one written.
REQ-011 SHALL ignore writes to 16'h4014 while busy_OUT=1; page and index stay unchanged.
REQ-012 SHALL keep a 1-bit cycle parity flop that toggles every clk, is 0 on the first cycle after reset and is never cleared by DMA.
REQ-013 SHALL take HALT->ALIGN only when the configuration feature is compiled in and parity=1 during HALT; otherwise HALT->READ.
REQ-014 SHALL take 513 cycles (no ALIGN) or 514 cycles (with ALIGN) from the first HALT cycle to the return to IDLE.
REQ-015 SHALL force dmaAddress_OUT=0, dmaData_OUT=0 and both strobes to 0 when dmaBusOwn_OUT=0.

Reset
REQ-016 SHALL, on reset_N=0, immediately set state=IDLE, page=0, index=0, byte register=0, parity=0, rdy_OUT=1, busy_OUT=0, dmaBusOwn_OUT=0, all strobes 0 and dmaAddress_OUT/dmaData_OUT=0.
REQ-017 SHALL abort a transfer when reset arrives mid-transfer; no further OAM write occurs after reset deasserts until a new trigger.

Configuration
REQ-018 SHALL use macro OAM_DMA_ODD_ALIGN_EN.
- Defined: ALIGN is inserted per REQ-013 (513/514-cycle transfers).
- Undefined: ALIGN is unreachable and every transfer is exactly 513 cycles.

Structure
REQ-019 SHALL take the state enum typedef and constants OAMDMA_ADDR=16'h4014 and OAMDATA_ADDR=16'h2004 from shared package cpu_bus_pkg.
REQ-020 SHALL be a single module with no sub-module; the counter, parity flop and FSM all live inline.

Verification
REQ-021 SHALL pass the basic transfer test: write 8'h02 to 4014 on an even-parity trigger cycle (so HALT lands on odd parity), macro undefined -> 256 reads 0200..02FF each followed by a write to 2004 with the matching data, rdy_OUT low for exactly 513 cycles.
REQ-022 SHALL pass the alignment test: same stimulus with the macro defined and HALT on parity=1 -> one ALIGN cycle, 514 cycles total; with HALT on parity=0 -> 513 cycles total.
REQ-023 SHALL pass the retrigger test: a second 4014 write with data 8'h07 at index 8'h40 -> ignored, page remains 8'h02, transfer completes normally.
REQ-024 SHALL pass the mid-transfer reset test: reset_N pulsed low at index 8'h80 in WRITE -> all outputs at reset values asynchronously, no 2004 write after release, rdy_OUT=1.
REQ-025 SHALL pass the page-boundary test: page 8'hFF -> last read at FFFF, exactly 256 writes, no access to 0000, returns to IDLE.
REQ-026 SHALL pass the decode test: CPU writes to 4013 and 4015 -> no trigger, rdy_OUT stays 1.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: OAM DMA state encoding and the two register
// addresses the DMA engine decodes or drives.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_e;

  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

  function automatic logic is_dma_trigger(input logic [15:0] addr, input logic we);
    return we && (addr == OAMDMA_ADDR);
  endfunction

endpackage

// File: rtl/oam_dma_controller.sv
// OAM DMA engine: copies a 256-byte CPU page into OAMDATA while halting the CPU.
// Optional build macro OAM_DMA_ODD_ALIGN_EN inserts an ALIGN cycle on odd-parity HALT.
module oam_dma_controller
  import cpu_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset_N,
  input  logic [15:0] cpuAddress_IN,
  input  logic [7:0]  cpuData_IN,
  input  logic        cpuWrite_EN,
  input  logic [7:0]  busData_IN,
  output logic        rdy_OUT,
  output logic        dmaBusOwn_OUT,
  output logic [15:0] dmaAddress_OUT,
  output logic [7:0]  dmaData_OUT,
  output logic        dmaRead_EN,
  output logic        dmaWrite_EN,
  output logic        busy_OUT
);

`ifdef OAM_DMA_ODD_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  dma_state_e  state;
  logic [7:0]  page_q;
  logic [7:0]  index_q;
  logic [7:0]  byte_q;
  logic        parity_q;
  logic        rdy_q;
  logic        busy_q;
  logic        own_q;
  logic [15:0] addr_q;
  logic        rd_q;
  logic        wr_q;

  // Bus outputs are registered against the state being entered, so each
  // output lines up exactly with the cycle its state occupies.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state    <= ST_IDLE;
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      byte_q   <= 8'h00;
      parity_q <= 1'b0;
      rdy_q    <= 1'b1;
      busy_q   <= 1'b0;
      own_q    <= 1'b0;
      addr_q   <= 16'h0000;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      parity_q <= ~parity_q;
      unique case (state)
        ST_IDLE: begin
          if (is_dma_trigger(cpuAddress_IN, cpuWrite_EN)) begin
            state   <= ST_HALT;
            page_q  <= cpuData_IN;
            index_q <= 8'h00;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_HALT: begin
          if (ALIGN_EN && parity_q) begin
            state <= ST_ALIGN;
          end else begin
            state  <= ST_READ;
            own_q  <= 1'b1;
            addr_q <= {page_q, index_q};
            rd_q   <= 1'b1;
          end
        end
        ST_ALIGN: begin
          state  <= ST_READ;
          own_q  <= 1'b1;
          addr_q <= {page_q, index_q};
          rd_q   <= 1'b1;
        end
        ST_READ: begin
          state  <= ST_WRITE;
          byte_q <= busData_IN;
          addr_q <= OAMDATA_ADDR;
          rd_q   <= 1'b0;
          wr_q   <= 1'b1;
        end
        ST_WRITE: begin
          index_q <= index_q + 8'd1;
          wr_q    <= 1'b0;
          // Index 255 is the final byte; the wrap to 0 never reaches a READ.
          if (index_q == 8'hFF) begin
            state  <= ST_IDLE;
            own_q  <= 1'b0;
            addr_q <= 16'h0000;
            rdy_q  <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            state  <= ST_READ;
            addr_q <= {page_q, index_q + 8'd1};
            rd_q   <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          own_q  <= 1'b0;
          addr_q <= 16'h0000;
          rd_q   <= 1'b0;
          wr_q   <= 1'b0;
          rdy_q  <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rdy_OUT        = rdy_q;
  assign busy_OUT       = busy_q;
  assign dmaBusOwn_OUT  = own_q;
  assign dmaAddress_OUT = addr_q;
  assign dmaRead_EN     = rd_q;
  assign dmaWrite_EN    = wr_q;
  // The byte register persists between transfers; only expose it while writing.
  assign dmaData_OUT    = wr_q ? byte_q : 8'h00;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed scoreboard bench for oam_dma_controller; expected bus accesses are
// queued at trigger time and popped as the DUT performs them.
module tb_oam_dma_controller;

`ifdef OAM_DMA_ODD_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_N;
  logic [15:0] cpuAddress_IN;
  logic [7:0]  cpuData_IN;
  logic        cpuWrite_EN;
  logic [7:0]  busData_IN;
  logic        rdy_OUT;
  logic        dmaBusOwn_OUT;
  logic [15:0] dmaAddress_OUT;
  logic [7:0]  dmaData_OUT;
  logic        dmaRead_EN;
  logic        dmaWrite_EN;
  logic        busy_OUT;

  always #5 clk = ~clk;

  oam_dma_controller dut (
    .clk            (clk),
    .reset_N        (reset_N),
    .cpuAddress_IN  (cpuAddress_IN),
    .cpuData_IN     (cpuData_IN),
    .cpuWrite_EN    (cpuWrite_EN),
    .busData_IN     (busData_IN),
    .rdy_OUT        (rdy_OUT),
    .dmaBusOwn_OUT  (dmaBusOwn_OUT),
    .dmaAddress_OUT (dmaAddress_OUT),
    .dmaData_OUT    (dmaData_OUT),
    .dmaRead_EN     (dmaRead_EN),
    .dmaWrite_EN    (dmaWrite_EN),
    .busy_OUT       (busy_OUT)
  );

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return (a[7:0] ^ 8'hA5) + a[15:8];
  endfunction

  assign busData_IN = dmaRead_EN ? mem_byte(dmaAddress_OUT) : 8'h00;

  // Cycle parity reference: 0 in the first cycle after reset, flips every edge.
  logic tb_par;
  always @(posedge clk or negedge reset_N) begin
    if (!reset_N) tb_par <= 1'b0;
    else          tb_par <= ~tb_par;
  end

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          low_cnt;
  int          wr_cnt;
  logic [15:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    ev_t e;
    @(negedge clk);
    if (!rdy_OUT) low_cnt++;
    chk("rdy_vs_busy", rdy_OUT, !busy_OUT);
    if (!dmaBusOwn_OUT)
      chk("idle_bus", {dmaAddress_OUT, dmaData_OUT, dmaRead_EN, dmaWrite_EN}, 32'h0);
    if (dmaRead_EN || dmaWrite_EN) begin
      if (exp_q.size() == 0) begin
        chk("spurious_access", {dmaRead_EN, dmaWrite_EN}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("bus_wr", dmaWrite_EN, e.wr);
        chk("bus_rd", dmaRead_EN, !e.wr);
        chk("bus_addr", dmaAddress_OUT, e.addr);
        if (e.wr) begin
          chk("bus_data", dmaData_OUT, e.data);
          wr_cnt++;
        end else begin
          last_rd = dmaAddress_OUT;
        end
      end
    end
  endtask

  task automatic trigger(input logic [7:0] page, input bit want_par, output int exp_len);
    ev_t e;
    bit  halt_par;
    for (int i = 0; i < 2 && tb_par !== want_par; i++) step();
    halt_par = !tb_par;
    exp_len  = (ALIGN_EN && halt_par) ? 514 : 513;
    for (int i = 0; i < 256; i++) begin
      e.wr = 1'b0; e.addr = {page, 8'(i)}; e.data = 8'h00;
      exp_q.push_back(e);
      e.wr = 1'b1; e.addr = 16'h2004; e.data = mem_byte({page, 8'(i)});
      exp_q.push_back(e);
    end
    low_cnt = 0;
    wr_cnt  = 0;
    cpuAddress_IN = 16'h4014;
    cpuData_IN    = page;
    cpuWrite_EN   = 1'b1;
    step();
    cpuAddress_IN = 16'h0000;
    cpuData_IN    = 8'h00;
    cpuWrite_EN   = 1'b0;
  endtask

  task automatic run_to_idle(input bit do_retrig, input bit do_rst, output bit aborted);
    int n = 0;
    bit retrig_done = 1'b0;
    aborted = 1'b0;
    while (!rdy_OUT && n < 600) begin
      step();
      n++;
      cpuWrite_EN   = 1'b0;
      cpuAddress_IN = 16'h0000;
      cpuData_IN    = 8'h00;
      if (do_retrig && !retrig_done && dmaRead_EN && dmaAddress_OUT[7:0] == 8'h40) begin
        cpuAddress_IN = 16'h4014;
        cpuData_IN    = 8'h07;
        cpuWrite_EN   = 1'b1;
        retrig_done   = 1'b1;
      end
      if (do_rst && dmaWrite_EN && last_rd[7:0] == 8'h80) begin
        #1 reset_N = 1'b0;
        #1;
        chk("rst_rdy", rdy_OUT, 1);
        chk("rst_busy", busy_OUT, 0);
        chk("rst_own", dmaBusOwn_OUT, 0);
        chk("rst_addr", dmaAddress_OUT, 0);
        chk("rst_data", dmaData_OUT, 0);
        chk("rst_strobes", {dmaRead_EN, dmaWrite_EN}, 0);
        exp_q.delete();
        @(negedge clk);
        reset_N = 1'b1;
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) chk("finish_in_bound", rdy_OUT, 1);
    if (do_retrig) chk("retrig_seen", retrig_done, 1);
  endtask

  task automatic check_done(input string tag, input int exp_len);
    chk({tag, "_rdy_low_cycles"}, low_cnt, exp_len);
    chk({tag, "_write_count"}, wr_cnt, 256);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int len;
    bit ab;
    reset_N       = 1'b0;
    cpuAddress_IN = 16'h0000;
    cpuData_IN    = 8'h00;
    cpuWrite_EN   = 1'b0;
    last_rd       = 16'h0000;
    low_cnt       = 0;
    wr_cnt        = 0;
    repeat (2) @(negedge clk);
    chk("reset_rdy", rdy_OUT, 1);
    chk("reset_busy", busy_OUT, 0);
    chk("reset_own", dmaBusOwn_OUT, 0);
    chk("reset_addr_data", {dmaAddress_OUT, dmaData_OUT}, 0);
    chk("reset_strobes", {dmaRead_EN, dmaWrite_EN}, 0);
    reset_N = 1'b1;
    repeat (3) step();

    // Basic transfer, trigger on even parity so HALT sits on odd parity.
    trigger(8'h02, 1'b0, len);
    run_to_idle(1'b0, 1'b0, ab);
    check_done("basic", len);

    // HALT on even parity: never aligned.
    trigger(8'h02, 1'b1, len);
    run_to_idle(1'b0, 1'b0, ab);
    check_done("even_halt", len);

    // Retrigger mid-transfer must be ignored.
    trigger(8'h02, 1'b0, len);
    run_to_idle(1'b1, 1'b0, ab);
    check_done("retrig", len);

    // Top page: last read FFFF, no wrap to 0000.
    trigger(8'hFF, 1'b0, len);
    run_to_idle(1'b0, 1'b0, ab);
    check_done("page_ff", len);
    chk("page_ff_last_read", last_rd, 16'hFFFF);

    // Neighbouring addresses must not trigger.
    cpuAddress_IN = 16'h4013; cpuData_IN = 8'h02; cpuWrite_EN = 1'b1;
    step();
    cpuAddress_IN = 16'h4015;
    step();
    cpuWrite_EN = 1'b0; cpuAddress_IN = 16'h0000; cpuData_IN = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("decode_rdy", rdy_OUT, 1);
    end

    // Reset at index 0x80 in WRITE aborts the transfer.
    trigger(8'h02, 1'b0, len);
    run_to_idle(1'b0, 1'b1, ab);
    chk("reset_abort_hit", ab, 1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("post_reset_rdy", rdy_OUT, 1);
    end

    // A fresh transfer after the abort runs to completion.
    trigger(8'h03, 1'b0, len);
    run_to_idle(1'b0, 1'b0, ab);
    check_done("after_reset", len);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
